// File: rtl/lcd_text_composer.sv
// Composes the two LCD text lines for the roulette game and hands complete frames
// to the LCD driver over a valid/ready handshake; money is shown via a serial BCD engine.
module lcd_text_composer #(
  parameter int COLS         = 16,
  parameter int MONEY_W      = 16,
  parameter int MONEY_DIGITS = 5,
  parameter int MONEY_MAX    = 10000,
  parameter int ZERO_PAD     = 1,
  parameter int BLINK_EN     = 1,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           state,
  input  logic [MONEY_W-1:0]   current_money,
  input  logic [11:0]          user_nums,
  input  logic [1:0]           num_store_idx,
  input  logic                 frame_ready,
  output logic [8*COLS-1:0]    line1,
  output logic [8*COLS-1:0]    line2,
  output logic                 frame_valid,
  output logic                 bcd_busy
);

  localparam int LW    = 8 * COLS;
  localparam int BCD_W = 4 * MONEY_DIGITS;
  localparam int CNT_W = $clog2(MONEY_W + 1);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [MONEY_W-1:0] MAX_V = MONEY_W'(MONEY_MAX);
  localparam logic [7:0] SP = 8'h20;

  typedef logic [127:0] txt_t;

  function automatic logic [MONEY_W-1:0] sat_money(input logic [MONEY_W-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // One double-dabble iteration: correct every digit >= 5, then shift the next binary bit in.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic in_bit);
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < MONEY_DIGITS; d++)
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    return {r[BCD_W-2:0], in_bit};
  endfunction

  function automatic logic [LW-1:0] put_chr(input logic [LW-1:0] ln, input int pos,
                                             input logic [7:0] c);
    logic [LW-1:0] r;
    r = ln;
    if (pos < COLS) r[8*(COLS-1-pos) +: 8] = c;
    return r;
  endfunction

  // Text literals arrive right-justified in 16 bytes; the highest non-zero byte marks the first char.
  function automatic logic [LW-1:0] put_str(input logic [LW-1:0] ln, input int pos, input txt_t s);
    logic [LW-1:0] r;
    int len;
    r   = ln;
    len = 0;
    for (int i = 0; i < 16; i++)
      if (s[8*i +: 8] != 8'h00) len = i + 1;
    for (int i = 0; i < 16; i++)
      if (i < len) r = put_chr(r, pos + i, s[8*(len-1-i) +: 8]);
    return r;
  endfunction

  function automatic logic [8*MONEY_DIGITS-1:0] money_text(input logic [BCD_W-1:0] bcd);
    logic [8*MONEY_DIGITS-1:0] t;
    logic [3:0] d;
    logic lead;
    lead = 1'b1;
    for (int i = 0; i < MONEY_DIGITS; i++) begin
      d = bcd[4*(MONEY_DIGITS-1-i) +: 4];
      if (d != 4'd0 || i == MONEY_DIGITS - 1) lead = 1'b0;
      t[8*(MONEY_DIGITS-1-i) +: 8] = (lead && ZERO_PAD == 0) ? SP : {4'h3, d};
    end
    return t;
  endfunction

  function automatic logic [LW-1:0] put_money(input logic [LW-1:0] ln, input int pos,
                                               input logic [8*MONEY_DIGITS-1:0] t);
    logic [LW-1:0] r;
    r = ln;
    for (int i = 0; i < MONEY_DIGITS; i++)
      r = put_chr(r, pos + i, t[8*(MONEY_DIGITS-1-i) +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] user_text(input logic [11:0] nums, input logic [1:0] idx,
                                            input logic blank);
    logic [31:0] t;
    for (int k = 0; k < 4; k++) begin
      t[8*(3-k) +: 8] = 8'h31 + {5'b0, nums[3*k +: 3]};
      if (blank && idx == 2'(k)) t[8*(3-k) +: 8] = 8'h5F;
    end
    return t;
  endfunction

  function automatic logic [LW-1:0] put_user(input logic [LW-1:0] ln, input int pos,
                                              input logic [31:0] t);
    logic [LW-1:0] r;
    r = ln;
    for (int k = 0; k < 4; k++) r = put_chr(r, pos + k, t[8*(3-k) +: 8]);
    return r;
  endfunction

  logic [MONEY_W-1:0]        money_clamped;
  logic [MONEY_W-1:0]        src;
  logic [MONEY_W-1:0]        shift_p0;
  logic [BCD_W-1:0]          acc_p0;
  logic [BCD_W-1:0]          money_bcd;
  logic [CNT_W-1:0]          bit_cnt;
  logic [3:0]                prev_state;
  logic [BLK_W-1:0]          blink_cnt;
  logic                      blink_ph;
  logic                      blank;
  logic [8*MONEY_DIGITS-1:0] m_txt;
  logic [31:0]               u_txt;
  logic [LW-1:0]             comp1_p0;
  logic [LW-1:0]             comp2_p0;
  logic [LW-1:0]             last1;
  logic [LW-1:0]             last2;

  assign money_clamped = sat_money(current_money);

  // Stage p0: serial binary-to-BCD; digits only change on the cycle bcd_busy falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src       <= '0;
      shift_p0  <= '0;
      acc_p0    <= '0;
      money_bcd <= '0;
      bit_cnt   <= '0;
      bcd_busy  <= 1'b0;
    end else if (bcd_busy) begin
      acc_p0   <= dd_step(acc_p0, shift_p0[MONEY_W-1]);
      shift_p0 <= {shift_p0[MONEY_W-2:0], 1'b0};
      bit_cnt  <= bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(MONEY_W - 1)) begin
        money_bcd <= dd_step(acc_p0, shift_p0[MONEY_W-1]);
        bcd_busy  <= 1'b0;
      end
    end else if (money_clamped != src) begin
      src      <= money_clamped;
      shift_p0 <= money_clamped;
      acc_p0   <= '0;
      bit_cnt  <= '0;
      bcd_busy <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= 4'd0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
    end else begin
      prev_state <= state;
      if (state != prev_state) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b0;
      end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  always_comb begin
    blank    = (BLINK_EN != 0) && blink_ph && (state == 4'd1 || state == 4'd3);
    m_txt    = money_text(money_bcd);
    u_txt    = user_text(user_nums, num_store_idx, blank);
    comp1_p0 = {COLS{SP}};
    comp2_p0 = {COLS{SP}};
    case (state)
      4'd0: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("PRESS * TO START"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("MONEY: "));
        comp2_p0 = put_money(comp2_p0, 7, m_txt);
      end
      4'd1: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("BET MONEY (OK)"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("[1~"));
        comp2_p0 = put_money(comp2_p0, 3, m_txt);
        comp2_p0 = put_str(comp2_p0, 3 + MONEY_DIGITS, txt_t'("]: "));
        comp2_p0 = put_user(comp2_p0, 6 + MONEY_DIGITS, u_txt);
      end
      4'd2: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("SELECT CNT [1~4]"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("CNT:"));
        comp2_p0 = put_chr(comp2_p0, 4, u_txt[31:24]);
        comp2_p0 = put_str(comp2_p0, 5, txt_t'(" OK:* CLR:#"));
      end
      4'd3: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("PICK NUM [1~8]"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("INPUT:"));
        comp2_p0 = put_user(comp2_p0, 6, u_txt);
        comp2_p0 = put_str(comp2_p0, 10, txt_t'(" CLR:#"));
      end
      4'd4: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("SPIN START!!"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("GOOD LUCK...!"));
      end
      4'd5: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("SLOWING DOWN..."));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("WAIT A MOMENT..!"));
      end
      4'd6: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("RESULT STOP!!"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("CHECKING..."));
      end
      4'd7: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("*YOU WIN!!*"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("MONEY: "));
        comp2_p0 = put_money(comp2_p0, 7, m_txt);
      end
      4'd8: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("TRY AGAIN..."));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("MONEY: "));
        comp2_p0 = put_money(comp2_p0, 7, m_txt);
      end
      4'd9: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("UPDATING MONEY"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("PLEASE WAIT..."));
      end
      4'd11: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("NEXT ROUND??"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("PRESS * TO GO!!"));
      end
      4'd12: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("GAME OVER!!"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("YOU LOST MONEY"));
      end
      4'd13: begin
        comp1_p0 = put_str(comp1_p0, 0, txt_t'("*GAME CLEAR*"));
        comp2_p0 = put_str(comp2_p0, 0, txt_t'("MONEY: "));
        comp2_p0 = put_money(comp2_p0, 7, m_txt);
        comp2_p0 = put_str(comp2_p0, 7 + MONEY_DIGITS, txt_t'("!!"));
      end
      default: ;
    endcase
  end

  // Stage p1: offered frame stays frozen while valid; a new one waits for a settled money field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line1       <= {COLS{SP}};
      line2       <= {COLS{SP}};
      last1       <= {COLS{SP}};
      last2       <= {COLS{SP}};
      frame_valid <= 1'b0;
    end else if (frame_valid) begin
      if (frame_ready) begin
        last1       <= line1;
        last2       <= line2;
        frame_valid <= 1'b0;
      end
    end else if (!bcd_busy && (comp1_p0 != last1 || comp2_p0 != last2)) begin
      line1       <= comp1_p0;
      line2       <= comp2_p0;
      frame_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_composer.sv
// Bench for lcd_text_composer: string-level screen model with per-cycle comparison
// plus directed scenarios with literal screen expectations.
module tb_lcd_text_composer;

  localparam int BD = 4;
  localparam logic [127:0] SPACES = {16{8'h20}};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state;
  logic [15:0] money;
  logic [11:0] nums;
  logic [1:0]  idx;
  logic        ready;
  logic [127:0] l1_a, l2_a, l1_b, l2_b;
  logic        fv_a, fv_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  lcd_text_composer #(.COLS(16), .MONEY_W(16), .MONEY_DIGITS(5), .MONEY_MAX(10000),
                      .ZERO_PAD(1), .BLINK_EN(1), .BLINK_DIV(BD)) dut_a (
    .clk(clk), .rst(rst), .state(state), .current_money(money), .user_nums(nums),
    .num_store_idx(idx), .frame_ready(ready), .line1(l1_a), .line2(l2_a),
    .frame_valid(fv_a), .bcd_busy(busy_a));

  lcd_text_composer #(.COLS(16), .MONEY_W(16), .MONEY_DIGITS(5), .MONEY_MAX(10000),
                      .ZERO_PAD(0), .BLINK_EN(1), .BLINK_DIV(BD)) dut_b (
    .clk(clk), .rst(rst), .state(state), .current_money(money), .user_nums(nums),
    .num_store_idx(idx), .frame_ready(ready), .line1(l1_b), .line2(l2_b),
    .frame_valid(fv_b), .bcd_busy(busy_b));

  task automatic chk_txt(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic chk_num(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] to_vec(string s);
    logic [127:0] v;
    v = SPACES;
    for (int i = 0; i < 16 && i < s.len(); i++) v[8*(15-i) +: 8] = s[i];
    return v;
  endfunction

  function automatic string text1(int st);
    case (st)
      0: return "PRESS * TO START";
      1: return "BET MONEY (OK)";
      2: return "SELECT CNT [1~4]";
      3: return "PICK NUM [1~8]";
      4: return "SPIN START!!";
      5: return "SLOWING DOWN...";
      6: return "RESULT STOP!!";
      7: return "*YOU WIN!!*";
      8: return "TRY AGAIN...";
      9: return "UPDATING MONEY";
      11: return "NEXT ROUND??";
      12: return "GAME OVER!!";
      13: return "*GAME CLEAR*";
      default: return "";
    endcase
  endfunction

  function automatic string text2(int st, int mv, bit zp, logic [11:0] nm, int ix, bit ph);
    string m, u;
    m = zp ? $sformatf("%05d", mv) : $sformatf("%5d", mv);
    u = $sformatf("%0d%0d%0d%0d", nm[2:0] + 1, nm[5:3] + 1, nm[8:6] + 1, nm[11:9] + 1);
    if ((st == 1 || st == 3) && ph) u.putc(ix, "_");
    case (st)
      0, 7, 8: return {"MONEY: ", m};
      1: return {"[1~", m, "]: ", u};
      2: return {"CNT:", u.substr(0, 0), " OK:* CLR:#"};
      3: return {"INPUT:", u, " CLR:#"};
      4: return "GOOD LUCK...!";
      5: return "WAIT A MOMENT..!";
      6: return "CHECKING...";
      9: return "PLEASE WAIT...";
      11: return "PRESS * TO GO!!";
      12: return "YOU LOST MONEY";
      13: return {"MONEY: ", m, "!!"};
      default: return "";
    endcase
  endfunction

  // Reference model: displayed money lags the clamped input by a 16-cycle conversion,
  // blink phase derives from cycles since the last state change.
  int           m_disp, m_src, m_left, m_since;
  int           m_prev;
  logic [127:0] m_l1 [2];
  logic [127:0] m_l2 [2];
  logic [127:0] m_last1 [2];
  logic [127:0] m_last2 [2];
  bit           m_valid [2];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_disp = 0; m_src = 0; m_left = 0; m_since = 0; m_prev = 0;
      for (int i = 0; i < 2; i++) begin
        m_l1[i] = SPACES; m_l2[i] = SPACES; m_last1[i] = SPACES; m_last2[i] = SPACES;
        m_valid[i] = 1'b0;
      end
    end else begin
      int cl;
      bit ph;
      logic [127:0] c1, c2;
      cl = (int'(money) > 10000) ? 10000 : int'(money);
      ph = ((m_since / BD) % 2) == 1;
      for (int i = 0; i < 2; i++) begin
        c1 = to_vec(text1(int'(state)));
        c2 = to_vec(text2(int'(state), m_disp, i == 0, nums, int'(idx), ph));
        if (m_valid[i]) begin
          if (ready) begin
            m_last1[i] = m_l1[i]; m_last2[i] = m_l2[i]; m_valid[i] = 1'b0;
          end
        end else if (m_left == 0 && (c1 != m_last1[i] || c2 != m_last2[i])) begin
          m_l1[i] = c1; m_l2[i] = c2; m_valid[i] = 1'b1;
        end
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_src;
      end else if (cl != m_src) begin
        m_src  = cl;
        m_left = 16;
      end
      if (int'(state) != m_prev) m_since = 0;
      else m_since++;
      m_prev = int'(state);
    end
  end

  initial forever begin
    @(negedge clk);
    chk_txt("a.line1", l1_a, m_l1[0]);
    chk_txt("a.line2", l2_a, m_l2[0]);
    chk_num("a.frame_valid", int'(fv_a), int'(m_valid[0]));
    chk_num("a.bcd_busy", int'(busy_a), int'(m_left > 0));
    chk_txt("b.line1", l1_b, m_l1[1]);
    chk_txt("b.line2", l2_b, m_l2[1]);
    chk_num("b.frame_valid", int'(fv_b), int'(m_valid[1]));
    chk_num("b.bcd_busy", int'(busy_b), int'(m_left > 0));
  end

  task automatic wait_valid(string name, int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (fv_a) ok = 1'b1;
    end
    chk_num(name, int'(ok), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int busy_n, val_n, nchg, cyc;
    logic [127:0] cap, prev;
    logic [127:0] chg [3];
    int tchg [3];

    rst = 1'b1; state = 4'd0; money = 16'd0; nums = 12'd0; idx = 2'd0; ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_txt("reset_line1", l1_a, SPACES);
    chk_num("reset_valid", int'(fv_a), 0);
    #1 rst = 1'b0;

    wait_valid("first_frame_seen", 5);
    chk_txt("first_line1", l1_a, to_vec("PRESS * TO START"));
    chk_txt("first_line2", l2_a, to_vec("MONEY: 00000"));
    val_n = 0;
    repeat (10) begin @(negedge clk); val_n += int'(fv_a); end
    chk_num("no_repeat_frame", val_n, 0);

    #1 money = 16'd123;
    busy_n = 0; val_n = 0; cap = SPACES;
    repeat (40) begin
      @(negedge clk);
      busy_n += int'(busy_a);
      if (fv_a) begin val_n++; cap = l2_a; end
    end
    chk_num("busy_cycles_123", busy_n, 16);
    chk_num("frames_123", val_n, 1);
    chk_txt("money_123", cap, to_vec("MONEY: 00123"));

    #1 money = 16'd20000;
    repeat (40) @(negedge clk);
    chk_txt("clamp_a", l2_a, to_vec("MONEY: 10000"));
    chk_txt("clamp_b", l2_b, to_vec("MONEY: 10000"));
    #1 money = 16'd7;
    repeat (40) @(negedge clk);
    chk_txt("blank_pad_b", l2_b, to_vec("MONEY:     7"));
    chk_txt("zero_pad_a", l2_a, to_vec("MONEY: 00007"));

    #1 ready = 1'b0; state = 4'd4;
    wait_valid("spin_offered", 5);
    chk_txt("spin_line1", l1_a, to_vec("SPIN START!!"));
    #1 state = 4'd5;
    repeat (5) @(negedge clk);
    chk_txt("spin_frozen", l1_a, to_vec("SPIN START!!"));
    chk_num("spin_still_valid", int'(fv_a), 1);
    #1 ready = 1'b1;
    @(negedge clk);
    chk_num("valid_dropped", int'(fv_a), 0);
    @(negedge clk);
    chk_num("slow_offered", int'(fv_a), 1);
    chk_txt("slow_line1", l1_a, to_vec("SLOWING DOWN..."));
    chk_txt("slow_line2", l2_a, to_vec("WAIT A MOMENT..!"));

    repeat (3) @(negedge clk);
    #1 state = 4'd2; nums = {3'd3, 3'd2, 3'd1, 3'd0}; idx = 2'd2;
    @(negedge clk);
    chk_txt("cnt_line2", l2_a, to_vec("CNT:1 OK:* CLR:#"));
    #1 state = 4'd3;
    prev = l2_a; nchg = 0;
    for (int i = 0; i < 3; i++) begin chg[i] = SPACES; tchg[i] = 0; end
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (l2_a != prev) begin
        if (nchg < 3) begin chg[nchg] = l2_a; tchg[nchg] = cyc; end
        nchg++;
        prev = l2_a;
      end
    end
    chk_txt("pick_line1", l1_a, to_vec("PICK NUM [1~8]"));
    chk_txt("blink_0", chg[0], to_vec("INPUT:1234 CLR:#"));
    chk_txt("blink_1", chg[1], to_vec("INPUT:12_4 CLR:#"));
    chk_txt("blink_2", chg[2], to_vec("INPUT:1234 CLR:#"));
    chk_num("blink_period", tchg[2] - tchg[1], 4);

    foreach (tchg[k]) tchg[k] = 0;
    for (int st = 0; st < 16; st++) begin
      #1 state = 4'(st); idx = 2'(st % 4);
      repeat (8) @(negedge clk);
      if (st == 13) chk_txt("clear_line2", l2_a, to_vec("MONEY: 00007!!"));
    end

    #1 state = 4'd0; money = 16'd300;
    repeat (3) @(negedge clk);
    #1 money = 16'd301;
    repeat (50) @(negedge clk);
    chk_txt("late_change", l2_a, to_vec("MONEY: 00301"));

    #1 money = 16'd500;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_num("rst_busy", int'(busy_a), 0);
    chk_num("rst_valid", int'(fv_a), 0);
    chk_txt("rst_line1", l1_a, SPACES);
    chk_txt("rst_line2_b", l2_b, SPACES);
    @(negedge clk);
    #1 rst = 1'b0;
    busy_n = 0;
    repeat (40) begin @(negedge clk); busy_n += int'(busy_a); end
    chk_num("busy_after_rst", busy_n, 16);
    chk_txt("money_500", l2_a, to_vec("MONEY: 00500"));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
